seq_detect_prog: RTL and testbench

//  Programmable serial bit-pattern detector; successor to the fixed-pattern hw2 detector.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_window.sv | 51 +++++
 rtl/seq_detect_prog.sv | 77 +++++++
 tb/tb_seq_detect_prog.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Width needed for a length field that must be able to hold pat_w itself.
  function automatic int len_w_for(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Next fill level: one more accepted bit, saturating at the window size.
  function automatic int min_fill(input int fill, input int cap);
    return (fill + 1 > cap) ? cap : fill + 1;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register, fill counter and masked pattern compare.
// match is combinational and valid in the cycle a bit is accepted.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w_for(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc,
  input  logic             din,
  input  logic             en,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_n;

  // Next history/fill and the masked compare of the newest len bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mask   = '0;
    hist_n = (hist << 1) | {{(PAT_W-1){1'b0}}, din};
    fill_n = LEN_W'(min_fill(int'(fill), PAT_W));
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match = acc && en && (fill_n >= len) && ((hist_n & mask) == (pat & mask));
  end

  // Shift accepted bits in; non-overlapping mode restarts the fill after a match.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (acc) begin
      hist <= hist_n;
      fill <= (match && !overlap) ? '0 : fill_n;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: shadow configuration, config
// error flag, registered match pulse and saturating match counter.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w_for(PAT_W),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             din_vld,
  input  logic             din,
  output logic             result,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  logic [PAT_W-1:0] pat_s;
  logic [LEN_W-1:0] len_s;
  logic             ovl_s;
  logic             acc;
  logic             match;

  // A bit on a cfg_load cycle is discarded.
  assign acc = din_vld && !cfg_load;

  // Shadow configuration; live inputs only matter on cfg_load.
  always_ff @(posedge clk) begin
    // NOTE: the shadow registers are reset to a defined, legal default (len=1), not left unknown.
    if (rst) begin
      pat_s   <= '0;
      len_s   <= LEN_W'(1);
      ovl_s   <= 1'b1;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      pat_s   <= pat;
      len_s   <= pat_len;
      ovl_s   <= overlap_en;
      cfg_err <= (pat_len == '0) || (int'(pat_len) > PAT_W);
    end
  end

  seq_det_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_load),
    .acc     (acc),
    .din     (din),
    .en      (!cfg_err),
    .overlap (ovl_s),
    .pat     (pat_s),
    .len     (len_s),
    .match   (match)
  );

  // Registered one-cycle match pulse and saturating match counter.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      result    <= 1'b0;
      match_cnt <= '0;
    end else begin
      result <= match;
      if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] pat_len = '0;
  logic       overlap_en = 1'b0;
  logic       din_vld = 1'b0;
  logic       din = 1'b0;

  logic        result;
  logic [15:0] match_cnt;
  logic        cfg_err;
  logic        result_s;
  logic [1:0]  match_cnt_s;
  logic        cfg_err_s;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state
  bit       q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_err;
  int       m_cnt;
  int       m_cnt_s;
  bit       m_res;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
    .overlap_en(overlap_en), .din_vld(din_vld), .din(din),
    .result(result), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
    .overlap_en(overlap_en), .din_vld(din_vld), .din(din),
    .result(result_s), .match_cnt(match_cnt_s), .cfg_err(cfg_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // True when the newest m_len accepted bits spell the pattern, oldest first.
  function automatic bit tail_matches();
    int base;
    if (m_err || q.size() < m_len) return 1'b0;
    base = q.size() - m_len;
    for (int k = 0; k < m_len; k++) begin
      if (q[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one clock cycle, advance the model, and compare all outputs.
  task automatic step(input bit r, input bit ld, input bit v, input bit d);
    rst = r; cfg_load = ld; din_vld = v; din = d;
    m_res = 1'b0;
    if (r) begin
      q.delete();
      m_pat = '0; m_len = 1; m_ovl = 1'b1; m_err = 1'b0;
      m_cnt = 0; m_cnt_s = 0;
    end else if (ld) begin
      q.delete();
      m_pat = pat; m_len = int'(pat_len); m_ovl = overlap_en;
      m_err = (pat_len == 0) || (pat_len > 8);
      m_cnt = 0; m_cnt_s = 0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > 8) void'(q.pop_front());
      if (tail_matches()) begin
        m_res = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
        if (!m_ovl) q.delete();
      end
    end
    @(posedge clk);
    #1;
    if (result === 1'b1) pulses++;
    check("result", 32'(result), 32'(m_res));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("match_cnt_s", 32'(match_cnt_s), 32'(m_cnt_s));
    check("result_s", 32'(result_s), 32'(m_res));
    rst = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    pat = p; pat_len = l; overlap_en = o;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    pulses = 0;
  endtask

  initial begin
    bit [17:0] seq2;
    int        exp_s[5];
    bit        r, ld, v;

    // 1: reset with live data on the input
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("t1_cnt_zero", 32'(match_cnt), 32'd0);

    // 2: five-bit overlapping pattern in a longer stream
    cfg(8'b0000_1110, 4'd5, 1'b1);
    seq2 = 18'b001110001101110000;
    for (int i = 17; i >= 0; i--) step(1'b0, 1'b0, 1'b1, seq2[i]);
    check("t2_pulses", 32'(pulses), 32'd2);
    check("t2_cnt", 32'(match_cnt), 32'd2);

    // 3: overlap vs non-overlap on a run of ones
    cfg(8'b0000_0011, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t3_ovl_pulses", 32'(pulses), 32'd3);
    check("t3_ovl_cnt", 32'(match_cnt), 32'd3);
    cfg(8'b0000_0011, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t3_novl_pulses", 32'(pulses), 32'd2);
    check("t3_novl_cnt", 32'(match_cnt), 32'd2);

    // 4: gaps in din_vld do not break a match
    cfg(8'b0000_0101, 4'd3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_cnt", 32'(match_cnt), 32'd1);

    // 5: illegal length disables detection until a legal load
    cfg(8'hff, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_err_set", 32'(cfg_err), 32'd1);
    check("t5_pulses", 32'(pulses), 32'd0);
    cfg(8'hff, 4'd9, 1'b1);
    check("t5_err_len9", 32'(cfg_err), 32'd1);
    cfg(8'h01, 4'd1, 1'b1);
    check("t5_err_clear", 32'(cfg_err), 32'd0);

    // 6: saturation of a 2-bit counter, then reset mid-stream
    cfg(8'h01, 4'd1, 1'b1);
    exp_s = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("t6_sat_cnt", 32'(match_cnt_s), 32'(exp_s[i]));
    end
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("t6_rst_result", 32'(result), 32'd0);
    check("t6_rst_cnt", 32'(match_cnt), 32'd0);

    // Randomized traffic with occasional reloads, illegal lengths and resets;
    // live config inputs wander freely between loads.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      pat        = 8'($urandom);
      overlap_en = 1'($urandom_range(0, 1));
      if (ld) begin
        case ($urandom_range(0, 9))
          0:       pat_len = 4'd0;
          1:       pat_len = 4'($urandom_range(9, 15));
          2, 3:    pat_len = 4'($urandom_range(5, 8));
          default: pat_len = 4'($urandom_range(1, 4));
        endcase
      end else begin
        pat_len = 4'($urandom);
      end
      step(r, ld, v, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
